lpddr2_avl_arbiter: RTL and testbench
=====================================

Name: lpddr2_avl_arbiter

Overview:
Two-master Avalon-MM burst arbiter in front of the LPDDR2 EMIF controller's single Avalon port. Master 0 is the radio_0 RX sample writer; master 1 is the radio_0 TX sample reader / CPU bridge. The block withholds access until memory calibration has succeeded, then grants whole bursts round-robin. It routes returning read data back to the issuing master through an in-order tag FIFO.

Parameters:
ADDR_W, 27, word address width on both sides
DATA_W, 32, data width; byteenable is DATA_W/8
BURST_W, 4, burstcount width; max burst is 2^(BURST_W-1) beats
MAX_PEND, 4, outstanding read commands tracked (tag FIFO depth, power of 2)

Ports:
clk_clk  in  1  system clock, same domain as EMIF avl clock
reset_reset_n  in  1  asynchronous active-low reset
local_init_done  in  1  EMIF status
local_cal_success  in  1  EMIF status
m<i>_address  in  ADDR_W  master i (i=0,1) address
m<i>_read / m<i>_write  in  1 each  master i command
m<i>_writedata  in  DATA_W  master i write data
m<i>_byteenable  in  DATA_W/8  master i byte enables
m<i>_burstcount  in  BURST_W  master i burst length
m<i>_waitrequest  out  1  stall to master i
m<i>_readdata  out  DATA_W  read data to master i
m<i>_readdatavalid  out  1  read beat valid to master i
s_address, s_read, s_write, s_writedata, s_byteenable, s_burstcount  out  as masters  to EMIF
s_waitrequest  in  1  EMIF stall
s_readdata  in  DATA_W  EMIF read data
s_readdatavalid  in  1  EMIF read beat valid
grant  out  2  one-hot current owner, debug/LED

Behaviour:
- Reset values: grant=0, s_read=0, s_write=0, m<i>_waitrequest=1, m<i>_readdatavalid=0, FIFO empty, rr pointer=0 (m0 preferred first).
- mem_ready = registered AND of local_init_done and local_cal_success (1-cycle sync). While low, no new grant; in-flight transaction completes.
- FSM states:
  - IDLE: if mem_ready and any request, register grant next cycle. A read request is eligible only if the tag FIFO is not full. With both eligible, pick the master not last granted. Go to WR if the winner is writing, else RD.
  - RD: s_* = granted master's signals (combinational mux); m_waitrequest = s_waitrequest for the owner, 1 for the other. On s_read & ~s_waitrequest: push {id, burstcount} and return to IDLE.
  - WR: mux as RD. The first accepted beat latches burstcount (0 treated as 1) into the beat counter; the counter decrements on each s_write & ~s_waitrequest. Return to IDLE after the beat with counter=1.
  - A granted master deasserting its request mid-WR keeps the grant (Avalon burst rule); s_write follows the master.
  - The non-owner always sees waitrequest=1. s_read and s_write are never both high.
- Latency: request to grant = 1 cycle, then pass-through. One idle bubble between transactions.
- Read return:
  - Each s_readdatavalid beat goes to FIFO head id; m<head>_readdatavalid = s_readdatavalid (combinational); readdata is broadcast to both masters.
  - The head beat counter decrements per beat; pop at last beat.
  - Push and pop in the same cycle are both honoured.
  - s_readdatavalid with the FIFO empty is dropped.
- Reset mid-burst: all state and FIFO cleared at once; late EMIF read beats are dropped by the empty-FIFO rule.

Test Plan:
- Calibration gate: hold cal_success=0, m0_write burst 4 -> m0_waitrequest=1 and s_write=0 throughout; raise cal_success -> grant=01 two cycles later, 4 beats pass, then IDLE.
- Round-robin: m0 and m1 write bursts of 2 continuously -> grants alternate 01,10,01,10; no beat lost; s_write never overlaps a foreign grant.
- Interleaved reads: m0 read burst 4 at A, m1 read burst 2 at B, EMIF returns 6 beats back-to-back -> first 4 on m0_readdatavalid, next 2 on m1_readdatavalid, FIFO empty after.
- FIFO full: 4 single-beat reads with EMIF data withheld -> 5th read held with waitrequest=1; first return beat frees a slot and the 5th is granted.
- Stalls/limits: s_waitrequest toggling during an 8-beat write -> exactly 8 accepted beats; burstcount=0 -> one beat.
- Reset mid-write: assert reset_reset_n=0 at beat 2 of 4 -> grant=0, s_write=0 immediately; stray readdatavalid after release produces no m<i>_readdatavalid.

Source files
------------

// File: rtl/lpddr2_avl_arbiter.sv
// Two-master Avalon-MM burst arbiter in front of the LPDDR2 EMIF port.
// Whole bursts are granted round-robin once calibration succeeds; read data returns through an in-order tag FIFO.
module lpddr2_avl_arbiter #(
  parameter int ADDR_W   = 27,
  parameter int DATA_W   = 32,
  parameter int BURST_W  = 4,
  parameter int MAX_PEND = 4
) (
  input  logic                  clk_clk,
  input  logic                  reset_reset_n,
  input  logic                  local_init_done,
  input  logic                  local_cal_success,
  input  logic [ADDR_W-1:0]     m0_address,
  input  logic                  m0_read,
  input  logic                  m0_write,
  input  logic [DATA_W-1:0]     m0_writedata,
  input  logic [DATA_W/8-1:0]   m0_byteenable,
  input  logic [BURST_W-1:0]    m0_burstcount,
  output logic                  m0_waitrequest,
  output logic [DATA_W-1:0]     m0_readdata,
  output logic                  m0_readdatavalid,
  input  logic [ADDR_W-1:0]     m1_address,
  input  logic                  m1_read,
  input  logic                  m1_write,
  input  logic [DATA_W-1:0]     m1_writedata,
  input  logic [DATA_W/8-1:0]   m1_byteenable,
  input  logic [BURST_W-1:0]    m1_burstcount,
  output logic                  m1_waitrequest,
  output logic [DATA_W-1:0]     m1_readdata,
  output logic                  m1_readdatavalid,
  output logic [ADDR_W-1:0]     s_address,
  output logic                  s_read,
  output logic                  s_write,
  output logic [DATA_W-1:0]     s_writedata,
  output logic [DATA_W/8-1:0]   s_byteenable,
  output logic [BURST_W-1:0]    s_burstcount,
  input  logic                  s_waitrequest,
  input  logic [DATA_W-1:0]     s_readdata,
  input  logic                  s_readdatavalid,
  output logic [1:0]            grant
);

  localparam int PTR_W = (MAX_PEND > 1) ? $clog2(MAX_PEND) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [BURST_W-1:0] ONE_B   = BURST_W'(1);
  localparam logic [PTR_W-1:0]   PTR_ONE = PTR_W'(1);
  localparam logic [CNT_W-1:0]   CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0]   DEPTH_C = CNT_W'(MAX_PEND);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [1:0]           grant_q, grant_d;
  logic                 pref_q, pref_d;
  logic [BURST_W-1:0]   cnt_q, cnt_d;
  logic                 first_q, first_d;
  logic                 mem_ready_q;

  logic                 fifo_id_q [MAX_PEND];
  logic [BURST_W-1:0]   fifo_bc_q [MAX_PEND];
  logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]     count_q;
  logic [BURST_W-1:0]   rd_beat_q;

  logic                 owner_s, fifo_full_s, fifo_empty_s;
  logic                 req0_s, req1_s, win_s, win_wr_s;
  logic                 push_s, pop_s, rdv_s, head_id_s;
  logic [BURST_W-1:0]   head_len_s, rem_s;

  // A burstcount of zero is treated as a single beat.
  function automatic logic [BURST_W-1:0] beats_f(input logic [BURST_W-1:0] bc);
    beats_f = (bc == '0) ? ONE_B : bc;
  endfunction

  assign owner_s      = grant_q[1];
  assign fifo_full_s  = (count_q == DEPTH_C);
  assign fifo_empty_s = (count_q == '0);
  assign req0_s       = m0_write | (m0_read & ~fifo_full_s);
  assign req1_s       = m1_write | (m1_read & ~fifo_full_s);
  assign win_s        = (req0_s & req1_s) ? pref_q : req1_s;
  assign win_wr_s     = win_s ? m1_write : m0_write;

  assign s_address    = owner_s ? m1_address    : m0_address;
  assign s_writedata  = owner_s ? m1_writedata  : m0_writedata;
  assign s_byteenable = owner_s ? m1_byteenable : m0_byteenable;
  assign s_burstcount = owner_s ? m1_burstcount : m0_burstcount;
  assign s_read       = (state_q == ST_RD) & (owner_s ? m1_read  : m0_read);
  assign s_write      = (state_q == ST_WR) & (owner_s ? m1_write : m0_write);

  assign m0_waitrequest = ~((state_q != ST_IDLE) & grant_q[0]) | s_waitrequest;
  assign m1_waitrequest = ~((state_q != ST_IDLE) & grant_q[1]) | s_waitrequest;
  assign grant          = grant_q;

  assign head_id_s        = fifo_id_q[rd_ptr_q];
  assign head_len_s       = beats_f(fifo_bc_q[rd_ptr_q]);
  assign rdv_s            = s_readdatavalid & ~fifo_empty_s;
  assign pop_s            = rdv_s & ((rd_beat_q + ONE_B) == head_len_s);
  assign m0_readdatavalid = rdv_s & ~head_id_s;
  assign m1_readdatavalid = rdv_s & head_id_s;
  assign m0_readdata      = s_readdata;
  assign m1_readdata      = s_readdata;

  // Arbitration and burst tracking next-state logic.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    pref_d  = pref_q;
    cnt_d   = cnt_q;
    first_d = first_q;
    push_s  = 1'b0;
    rem_s   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (mem_ready_q && (req0_s || req1_s)) begin
          grant_d = win_s ? 2'b10 : 2'b01;
          pref_d  = ~win_s;
          first_d = 1'b1;
          state_d = win_wr_s ? ST_WR : ST_RD;
        end else begin
          grant_d = 2'b00;
        end
      end
      ST_RD: begin
        if (s_read && !s_waitrequest) begin
          push_s  = 1'b1;
          state_d = ST_IDLE;
          grant_d = 2'b00;
        end else begin
          state_d = ST_RD;
        end
      end
      ST_WR: begin
        // The master's burstcount is only valid on the first beat, so it is captured there.
        rem_s = first_q ? beats_f(s_burstcount) : cnt_q;
        if (s_write && !s_waitrequest) begin
          first_d = 1'b0;
          if (rem_s == ONE_B) begin
            state_d = ST_IDLE;
            grant_d = 2'b00;
          end else begin
            cnt_d = rem_s - ONE_B;
          end
        end else begin
          state_d = ST_WR;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = 2'b00;
      end
    endcase
  end

  // Arbiter state registers and calibration gate.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q     <= ST_IDLE;
      grant_q     <= 2'b00;
      pref_q      <= 1'b0;
      cnt_q       <= '0;
      first_q     <= 1'b0;
      mem_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      pref_q      <= pref_d;
      cnt_q       <= cnt_d;
      first_q     <= first_d;
      mem_ready_q <= local_init_done & local_cal_success;
    end
  end

  // Read tag FIFO: one entry per accepted read command, popped on its last returning beat.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rd_beat_q <= '0;
      for (int i = 0; i < MAX_PEND; i++) begin
        fifo_id_q[i] <= 1'b0;
        fifo_bc_q[i] <= '0;
      end
    end else begin
      if (push_s) begin
        fifo_id_q[wr_ptr_q] <= owner_s;
        fifo_bc_q[wr_ptr_q] <= s_burstcount;
        wr_ptr_q            <= wr_ptr_q + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_q  <= rd_ptr_q + PTR_ONE;
        rd_beat_q <= '0;
      end else if (rdv_s) begin
        rd_beat_q <= rd_beat_q + ONE_B;
      end
      case ({push_s, pop_s})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_lpddr2_avl_arbiter.sv
// Directed self-checking bench for lpddr2_avl_arbiter: calibration gate, round-robin,
// read return routing, tag FIFO full, stalls, zero burstcount and reset mid-burst.
module tb_lpddr2_avl_arbiter;

  logic        clk_clk = 1'b0;
  logic        reset_reset_n;
  logic        local_init_done, local_cal_success;
  logic [26:0] m0_address, m1_address, s_address;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [31:0] m0_writedata, m1_writedata, s_writedata;
  logic [3:0]  m0_byteenable, m1_byteenable, s_byteenable;
  logic [3:0]  m0_burstcount, m1_burstcount, s_burstcount;
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] m0_readdata, m1_readdata;
  logic        m0_readdatavalid, m1_readdatavalid;
  logic        s_read, s_write, s_waitrequest, s_readdatavalid;
  logic [31:0] s_readdata;
  logic [1:0]  grant;

  int n_checks = 0;
  int n_errors = 0;

  lpddr2_avl_arbiter dut (
    .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
    .local_init_done(local_init_done), .local_cal_success(local_cal_success),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
    .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable), .m0_burstcount(m0_burstcount),
    .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable), .m1_burstcount(m1_burstcount),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .s_address(s_address), .s_read(s_read), .s_write(s_write), .s_writedata(s_writedata),
    .s_byteenable(s_byteenable), .s_burstcount(s_burstcount), .s_waitrequest(s_waitrequest),
    .s_readdata(s_readdata), .s_readdatavalid(s_readdatavalid), .grant(grant)
  );

  always #5 clk_clk = ~clk_clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_clk);
  endtask

  task automatic clear_masters();
    m0_address = 27'h0; m0_read = 1'b0; m0_write = 1'b0; m0_writedata = 32'h0;
    m0_byteenable = 4'hF; m0_burstcount = 4'd1;
    m1_address = 27'h0; m1_read = 1'b0; m1_write = 1'b0; m1_writedata = 32'h0;
    m1_byteenable = 4'hF; m1_burstcount = 4'd1;
  endtask

  task automatic do_reset();
    tick();
    reset_reset_n = 1'b0;
    clear_masters();
    s_waitrequest = 1'b0;
    s_readdatavalid = 1'b0;
    tick();
    reset_reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int acc, ng, ovl;
    int beat0, beat1;
    logic [1:0] gseq [4];
    logic [1:0] prev_g;

    reset_reset_n = 1'b0;
    local_init_done = 1'b1;
    local_cal_success = 1'b0;
    clear_masters();
    s_waitrequest = 1'b0;
    s_readdata = 32'h0;
    s_readdatavalid = 1'b1;
    tick();
    check("rst_grant", grant, 2'b00);
    check("rst_s_write", s_write, 1'b0);
    check("rst_s_read", s_read, 1'b0);
    check("rst_m0_wait", m0_waitrequest, 1'b1);
    check("rst_m1_wait", m1_waitrequest, 1'b1);
    check("rst_m0_rdv", m0_readdatavalid, 1'b0);
    check("rst_m1_rdv", m1_readdatavalid, 1'b0);
    s_readdatavalid = 1'b0;
    reset_reset_n = 1'b1;

    // Calibration gate
    m0_write = 1'b1; m0_burstcount = 4'd4; m0_address = 27'h123_4567;
    for (int k = 0; k < 5; k++) begin
      tick(); #1;
      check("gate_m0_wait", m0_waitrequest, 1'b1);
      check("gate_s_write", s_write, 1'b0);
      check("gate_grant", grant, 2'b00);
    end
    local_cal_success = 1'b1;
    tick(); #1;
    check("gate_grant_1cyc", grant, 2'b00);
    tick(); #1;
    check("gate_grant_2cyc", grant, 2'b01);
    for (int b = 0; b < 4; b++) begin
      m0_writedata = 32'hD0D0_0000 + b;
      #1;
      check("gate_beat_s_write", s_write, 1'b1);
      check("gate_beat_wdata", s_writedata, 32'hD0D0_0000 + b);
      check("gate_beat_addr", s_address, 27'h123_4567);
      check("gate_beat_m0_wait", m0_waitrequest, 1'b0);
      check("gate_beat_m1_wait", m1_waitrequest, 1'b1);
      tick();
    end
    m0_write = 1'b0;
    #1;
    check("gate_end_grant", grant, 2'b00);
    check("gate_end_s_write", s_write, 1'b0);

    // Round-robin between two continuous writers
    do_reset();
    beat0 = 0; beat1 = 0; ng = 0; ovl = 0; prev_g = 2'b00;
    for (int i = 0; i < 4; i++) gseq[i] = 2'b00;
    for (int k = 1; k <= 13; k++) begin
      tick();
      m0_write = 1'b1; m0_burstcount = 4'd2; m0_address = 27'h000_0100;
      m1_write = 1'b1; m1_burstcount = 4'd2; m1_address = 27'h000_0200;
      m0_writedata = 32'hA000_0000 + beat0;
      m1_writedata = 32'hA001_0000 + beat1;
      #1;
      if (grant != 2'b00 && grant != prev_g && ng < 4) begin
        gseq[ng] = grant;
        ng++;
      end
      prev_g = grant;
      if (s_write && !((grant == 2'b01 && s_writedata == m0_writedata) ||
                       (grant == 2'b10 && s_writedata == m1_writedata))) ovl++;
      if (s_read && s_write) ovl++;
      if (m0_write && !m0_waitrequest) beat0++;
      if (m1_write && !m1_waitrequest) beat1++;
    end
    check("rr_grant0", gseq[0], 2'b01);
    check("rr_grant1", gseq[1], 2'b10);
    check("rr_grant2", gseq[2], 2'b01);
    check("rr_grant3", gseq[3], 2'b10);
    check("rr_m0_beats", beat0, 4);
    check("rr_m1_beats", beat1, 4);
    check("rr_overlap", ovl, 0);

    // Interleaved reads routed back through the tag FIFO
    do_reset();
    tick();
    m0_read = 1'b1; m0_burstcount = 4'd4; m0_address = 27'h0AA_0000;
    m1_read = 1'b1; m1_burstcount = 4'd2; m1_address = 27'h0BB_0000;
    #1;
    check("rd_idle_grant", grant, 2'b00);
    tick(); #1;
    check("rd_m0_grant", grant, 2'b01);
    check("rd_m0_s_read", s_read, 1'b1);
    check("rd_m0_s_write", s_write, 1'b0);
    check("rd_m0_addr", s_address, 27'h0AA_0000);
    check("rd_m0_bc", s_burstcount, 4'd4);
    check("rd_m0_wait", m0_waitrequest, 1'b0);
    check("rd_m1_held", m1_waitrequest, 1'b1);
    tick();
    m0_read = 1'b0;
    #1;
    check("rd_bubble_grant", grant, 2'b00);
    tick(); #1;
    check("rd_m1_grant", grant, 2'b10);
    check("rd_m1_addr", s_address, 27'h0BB_0000);
    check("rd_m1_bc", s_burstcount, 4'd2);
    check("rd_m1_wait", m1_waitrequest, 1'b0);
    check("rd_m0_held", m0_waitrequest, 1'b1);
    tick();
    m1_read = 1'b0;
    for (int j = 0; j < 6; j++) begin
      s_readdatavalid = 1'b1;
      s_readdata = 32'hBEEF_0000 + j;
      #1;
      check("ret_m0_rdv", m0_readdatavalid, (j < 4) ? 1'b1 : 1'b0);
      check("ret_m1_rdv", m1_readdatavalid, (j >= 4) ? 1'b1 : 1'b0);
      check("ret_m0_data", m0_readdata, 32'hBEEF_0000 + j);
      check("ret_m1_data", m1_readdata, 32'hBEEF_0000 + j);
      tick();
    end
    s_readdatavalid = 1'b1;
    #1;
    check("ret_empty_m0_rdv", m0_readdatavalid, 1'b0);
    check("ret_empty_m1_rdv", m1_readdatavalid, 1'b0);
    tick();
    s_readdatavalid = 1'b0;

    // Tag FIFO full holds a fifth read until a slot frees
    do_reset();
    acc = 0;
    for (int k = 1; k <= 14; k++) begin
      tick();
      m0_read = 1'b1; m0_burstcount = 4'd1; m0_address = 27'h000_0100 + 27'(acc);
      #1;
      if (m0_read && !m0_waitrequest) acc++;
    end
    check("full_accepts", acc, 4);
    check("full_m0_wait", m0_waitrequest, 1'b1);
    check("full_grant", grant, 2'b00);
    tick();
    s_readdatavalid = 1'b1; s_readdata = 32'h1234_5678;
    #1;
    check("full_ret_rdv", m0_readdatavalid, 1'b1);
    check("full_ret_wait", m0_waitrequest, 1'b1);
    tick();
    s_readdatavalid = 1'b0;
    #1;
    check("full_pop_grant", grant, 2'b00);
    tick(); #1;
    check("full_5th_grant", grant, 2'b01);
    check("full_5th_wait", m0_waitrequest, 1'b0);
    check("full_5th_s_read", s_read, 1'b1);
    tick();
    m0_read = 1'b0;

    // 8-beat write with s_waitrequest toggling
    do_reset();
    acc = 0; ng = 0; prev_g = 2'b00;
    for (int k = 1; k <= 40 && acc < 8; k++) begin
      tick();
      s_waitrequest = k[0];
      m0_write = 1'b1; m0_burstcount = 4'd8; m0_address = 27'h000_0800;
      m0_writedata = 32'h5500_0000 + acc;
      #1;
      if (grant == 2'b01 && prev_g != 2'b01) ng++;
      prev_g = grant;
      if (m0_write && !m0_waitrequest) begin
        check("stall_wdata", s_writedata, 32'h5500_0000 + acc);
        acc++;
      end
    end
    tick();
    m0_write = 1'b0;
    s_waitrequest = 1'b0;
    #1;
    check("stall_beats", acc, 8);
    check("stall_grants", ng, 1);
    check("stall_end_grant", grant, 2'b00);

    // burstcount of zero is a single beat
    tick();
    m0_write = 1'b1; m0_burstcount = 4'd0; m0_writedata = 32'h0000_00B0;
    #1;
    check("bc0_idle_grant", grant, 2'b00);
    tick(); #1;
    check("bc0_grant", grant, 2'b01);
    check("bc0_m0_wait", m0_waitrequest, 1'b0);
    check("bc0_s_write", s_write, 1'b1);
    tick();
    m0_write = 1'b0;
    #1;
    check("bc0_end_grant", grant, 2'b00);

    // Reset asserted at beat 2 of a 4-beat write
    do_reset();
    tick();
    m0_write = 1'b1; m0_burstcount = 4'd4; m0_writedata = 32'h0;
    tick(); #1;
    check("rstw_grant", grant, 2'b01);
    tick();
    m0_writedata = 32'h1;
    tick();
    m0_writedata = 32'h2;
    reset_reset_n = 1'b0;
    #1;
    check("rstw_grant_clr", grant, 2'b00);
    check("rstw_s_write_clr", s_write, 1'b0);
    check("rstw_m0_wait", m0_waitrequest, 1'b1);
    tick();
    reset_reset_n = 1'b1;
    clear_masters();
    for (int k = 0; k < 3; k++) begin
      tick();
      s_readdatavalid = 1'b1;
      s_readdata = 32'hDEAD_0000 + k;
      #1;
      check("rstw_stray_m0_rdv", m0_readdatavalid, 1'b0);
      check("rstw_stray_m1_rdv", m1_readdatavalid, 1'b0);
    end
    s_readdatavalid = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
